// File: rtl/fpro_mmio_arbiter.sv
// Two-master round-robin arbiter in front of the FPro MMIO bus.
// Each granted request becomes one single-cycle cs/wr/rd strobe followed by an ack pulse.
module fpro_mmio_arbiter #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wr_data,
    output logic [DATA_W-1:0] m0_rd_data,
    output logic              m0_ack,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wr_data,
    output logic [DATA_W-1:0] m1_rd_data,
    output logic              m1_ack,
    output logic              mmio_cs,
    output logic              mmio_wr,
    output logic              mmio_rd,
    output logic [ADDR_W-1:0] mmio_addr,
    output logic [DATA_W-1:0] mmio_wr_data,
    input  logic [DATA_W-1:0] mmio_rd_data,
    output logic              busy,
    output logic              gnt_id
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        ACK
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              last;
    logic              win_valid;
    logic              win_id;
    logic              win_wr;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wr_data;

    // Under contention the master that did not own the previous transaction wins.
    always_comb begin
        win_valid = m0_req | m1_req;
        if (m0_req && m1_req) begin
            win_id = ~last;
        end else begin
            win_id = m1_req;
        end
        win_wr      = win_id ? m1_wr      : m0_wr;
        win_addr    = win_id ? m1_addr    : m0_addr;
        win_wr_data = win_id ? m1_wr_data : m0_wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (win_valid) state_next = ISSUE;
            ISSUE:   state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // Strobes and acks are registered one state ahead so they line up with ISSUE and ACK.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mmio_cs      <= 1'b0;
            mmio_wr      <= 1'b0;
            mmio_rd      <= 1'b0;
            mmio_addr    <= '0;
            mmio_wr_data <= '0;
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
            m0_rd_data   <= '0;
            m1_rd_data   <= '0;
            gnt_id       <= 1'b0;
            last         <= 1'b1;
        end else begin
            mmio_cs <= 1'b0;
            mmio_wr <= 1'b0;
            mmio_rd <= 1'b0;
            m0_ack  <= 1'b0;
            m1_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        mmio_cs      <= 1'b1;
                        mmio_wr      <= win_wr;
                        mmio_rd      <= ~win_wr;
                        mmio_addr    <= win_addr;
                        mmio_wr_data <= win_wr_data;
                        gnt_id       <= win_id;
                    end
                end
                ISSUE: begin
                    if (gnt_id) begin
                        m1_ack <= 1'b1;
                        if (mmio_rd) m1_rd_data <= mmio_rd_data;
                    end else begin
                        m0_ack <= 1'b1;
                        if (mmio_rd) m0_rd_data <= mmio_rd_data;
                    end
                end
                ACK: begin
                    last <= gnt_id;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpro_mmio_arbiter.sv
// Directed self-checking bench for fpro_mmio_arbiter: latency, data routing,
// round-robin ordering and asynchronous reset in the middle of a transaction.
module tb_fpro_mmio_arbiter;

    localparam int ADDR_W = 21;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              m0_req = 1'b0, m0_wr = 1'b0;
    logic [ADDR_W-1:0] m0_addr = '0;
    logic [DATA_W-1:0] m0_wr_data = '0;
    logic [DATA_W-1:0] m0_rd_data;
    logic              m0_ack;
    logic              m1_req = 1'b0, m1_wr = 1'b0;
    logic [ADDR_W-1:0] m1_addr = '0;
    logic [DATA_W-1:0] m1_wr_data = '0;
    logic [DATA_W-1:0] m1_rd_data;
    logic              m1_ack;
    logic              mmio_cs, mmio_wr, mmio_rd;
    logic [ADDR_W-1:0] mmio_addr;
    logic [DATA_W-1:0] mmio_wr_data;
    logic [DATA_W-1:0] mmio_rd_data = '0;
    logic              busy, gnt_id;

    int n_checks = 0;
    int n_fail   = 0;

    fpro_mmio_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
        .m0_rd_data(m0_rd_data), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
        .m1_rd_data(m1_rd_data), .m1_ack(m1_ack),
        .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
        .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data), .mmio_rd_data(mmio_rd_data),
        .busy(busy), .gnt_id(gnt_id)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        logic [3:0] strobes;
        #2;
        strobes = {mmio_cs, mmio_wr, mmio_rd, busy};
        n_checks++;
        if (strobes !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_strobes got %b want 0000", strobes); end
        n_checks++;
        if ({m0_ack, m1_ack, gnt_id} !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_ack_gnt got %b want 000", {m0_ack, m1_ack, gnt_id}); end
        n_checks++;
        if (mmio_addr !== '0 || mmio_wr_data !== '0) begin n_fail++; $display("[TB] FAIL reset_bus got %h/%h want 0/0", mmio_addr, mmio_wr_data); end
        n_checks++;
        if (m0_rd_data !== '0 || m1_rd_data !== '0) begin n_fail++; $display("[TB] FAIL reset_rd_data got %h/%h want 0/0", m0_rd_data, m1_rd_data); end
        do_reset();
    endtask

    task automatic test_single_read();
        m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 21'h000042;
        mmio_rd_data = 32'hDEADBEEF;
        #1;
        n_checks++;
        if (mmio_cs !== 1'b0) begin n_fail++; $display("[TB] FAIL read_cs_T got %b want 0", mmio_cs); end
        step();
        n_checks++;
        if ({mmio_cs, mmio_rd, mmio_wr} !== 3'b110 || mmio_addr !== 21'h000042) begin
            n_fail++; $display("[TB] FAIL read_strobe_T1 got cs/rd/wr=%b addr=%h want 110 addr=000042", {mmio_cs, mmio_rd, mmio_wr}, mmio_addr);
        end
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL read_busy_T1 got %b want 1", busy); end
        step();
        n_checks++;
        if (m0_ack !== 1'b1 || m1_ack !== 1'b0 || m0_rd_data !== 32'hDEADBEEF) begin
            n_fail++; $display("[TB] FAIL read_ack_T2 got ack0=%b ack1=%b data=%h want 1 0 deadbeef", m0_ack, m1_ack, m0_rd_data);
        end
        n_checks++;
        if (mmio_cs !== 1'b0) begin n_fail++; $display("[TB] FAIL read_cs_T2 got %b want 0", mmio_cs); end
        m0_req = 1'b0;
        step();
        n_checks++;
        if (busy !== 1'b0 || m0_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL read_idle_T3 got busy=%b ack=%b want 0 0", busy, m0_ack); end
        n_checks++;
        if (m1_rd_data !== '0) begin n_fail++; $display("[TB] FAIL read_other_data got %h want 0", m1_rd_data); end
        step();
    endtask

    task automatic test_single_write();
        m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 21'h000100; m1_wr_data = 32'h12345678;
        mmio_rd_data = 32'hCAFEF00D;
        step();
        n_checks++;
        if ({mmio_cs, mmio_wr, mmio_rd} !== 3'b110 || mmio_addr !== 21'h000100 || mmio_wr_data !== 32'h12345678) begin
            n_fail++; $display("[TB] FAIL write_strobe_T1 got cs/wr/rd=%b addr=%h data=%h want 110 000100 12345678", {mmio_cs, mmio_wr, mmio_rd}, mmio_addr, mmio_wr_data);
        end
        step();
        n_checks++;
        if (m1_ack !== 1'b1 || m0_ack !== 1'b0 || mmio_wr !== 1'b0) begin
            n_fail++; $display("[TB] FAIL write_ack_T2 got ack1=%b ack0=%b wr=%b want 1 0 0", m1_ack, m0_ack, mmio_wr);
        end
        n_checks++;
        if (m1_rd_data !== '0 || m0_rd_data !== 32'hDEADBEEF) begin
            n_fail++; $display("[TB] FAIL write_rd_data got m1=%h m0=%h want 0 deadbeef", m1_rd_data, m0_rd_data);
        end
        n_checks++;
        if (gnt_id !== 1'b1) begin n_fail++; $display("[TB] FAIL write_gnt got %b want 1", gnt_id); end
        m1_req = 1'b0;
        step();
        n_checks++;
        if (mmio_addr !== 21'h000100 || mmio_wr_data !== 32'h12345678) begin
            n_fail++; $display("[TB] FAIL write_hold got %h/%h want 000100/12345678", mmio_addr, mmio_wr_data);
        end
        step();
    endtask

    task automatic test_contention();
        do_reset();
        m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 21'h000010; m0_wr_data = 32'hA0A0A0A0;
        m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 21'h000020; m1_wr_data = 32'hB1B1B1B1;
        step();
        n_checks++;
        if (mmio_cs !== 1'b1 || mmio_addr !== 21'h000010) begin n_fail++; $display("[TB] FAIL cont_first_strobe got cs=%b addr=%h want 1 000010", mmio_cs, mmio_addr); end
        step();
        n_checks++;
        if (m0_ack !== 1'b1 || m1_ack !== 1'b0 || gnt_id !== 1'b0) begin
            n_fail++; $display("[TB] FAIL cont_first_ack got ack0=%b ack1=%b gnt=%b want 1 0 0", m0_ack, m1_ack, gnt_id);
        end
        m0_req = 1'b0;
        step();
        n_checks++;
        if (mmio_cs !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL cont_idle_T3 got cs=%b busy=%b want 0 0", mmio_cs, busy); end
        step();
        n_checks++;
        if (mmio_cs !== 1'b1 || mmio_wr_data !== 32'hB1B1B1B1 || gnt_id !== 1'b1) begin
            n_fail++; $display("[TB] FAIL cont_second_strobe_T4 got cs=%b data=%h gnt=%b want 1 b1b1b1b1 1", mmio_cs, mmio_wr_data, gnt_id);
        end
        step();
        n_checks++;
        if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL cont_second_ack_T5 got ack1=%b ack0=%b want 1 0", m1_ack, m0_ack); end
        m1_req = 1'b0;
        step();
        step();
    endtask

    task automatic test_sustained();
        logic prev_cs;
        int   txn;
        do_reset();
        m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 21'h000aaa;
        m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 21'h000bbb;
        mmio_rd_data = 32'h55AA55AA;
        prev_cs = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            step();
            txn = (i - 1) / 3;
            n_checks++;
            if (mmio_cs !== (i % 3 == 1)) begin n_fail++; $display("[TB] FAIL sus_cs_cycle%0d got %b want %b", i, mmio_cs, (i % 3 == 1)); end
            if (prev_cs && mmio_cs) begin n_fail++; $display("[TB] FAIL sus_cs_twice cycle%0d got 1 want 0", i); end
            if (i % 3 == 1) begin
                n_checks++;
                if (gnt_id !== txn[0] || mmio_addr !== (txn[0] ? 21'h000bbb : 21'h000aaa)) begin
                    n_fail++; $display("[TB] FAIL sus_gnt_txn%0d got gnt=%b addr=%h want %b", txn, gnt_id, mmio_addr, txn[0]);
                end
            end
            if (i % 3 == 2) begin
                n_checks++;
                if ({m1_ack, m0_ack} !== (txn[0] ? 2'b10 : 2'b01)) begin
                    n_fail++; $display("[TB] FAIL sus_ack_txn%0d got %b want %b", txn, {m1_ack, m0_ack}, (txn[0] ? 2'b10 : 2'b01));
                end
            end
            prev_cs = mmio_cs;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        n_checks++;
        if (m1_rd_data !== 32'h55AA55AA) begin n_fail++; $display("[TB] FAIL sus_m1_data got %h want 55aa55aa", m1_rd_data); end
        step();
        step();
    endtask

    task automatic test_reset_mid_op();
        m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 21'h000077;
        mmio_rd_data = 32'h0BADF00D;
        step();
        reset = 1'b1;
        #1;
        n_checks++;
        if ({mmio_cs, mmio_rd, mmio_wr, busy, m0_ack, m1_ack} !== 6'b0) begin
            n_fail++; $display("[TB] FAIL rst_mid_outputs got %b want 000000", {mmio_cs, mmio_rd, mmio_wr, busy, m0_ack, m1_ack});
        end
        n_checks++;
        if (mmio_addr !== '0 || m0_rd_data !== '0 || m1_rd_data !== '0) begin
            n_fail++; $display("[TB] FAIL rst_mid_regs got addr=%h d0=%h d1=%h want 0", mmio_addr, m0_rd_data, m1_rd_data);
        end
        m0_req = 1'b0;
        step();
        n_checks++;
        if (m0_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid_no_ack got %b want 0", m0_ack); end
        reset = 1'b0;
        step();
        n_checks++;
        if (m0_ack !== 1'b0 || mmio_cs !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid_quiet got ack=%b cs=%b want 0 0", m0_ack, mmio_cs); end
        m0_req = 1'b1;
        step();
        n_checks++;
        if (mmio_cs !== 1'b1 || mmio_rd !== 1'b1 || mmio_addr !== 21'h000077) begin
            n_fail++; $display("[TB] FAIL rst_reissue_strobe got cs=%b rd=%b addr=%h want 1 1 000077", mmio_cs, mmio_rd, mmio_addr);
        end
        step();
        n_checks++;
        if (m0_ack !== 1'b1 || m0_rd_data !== 32'h0BADF00D) begin
            n_fail++; $display("[TB] FAIL rst_reissue_ack got ack=%b data=%h want 1 0badf00d", m0_ack, m0_rd_data);
        end
        m0_req = 1'b0;
        step();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_reissue_idle got %b want 0", busy); end
        step();
    endtask

    task automatic test_late_request();
        m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 21'h000300; m0_wr_data = 32'h11112222;
        step();
        m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 21'h000400; m1_wr_data = 32'h33334444;
        step();
        n_checks++;
        if (m0_ack !== 1'b1 || mmio_cs !== 1'b0) begin n_fail++; $display("[TB] FAIL late_m0_ack got ack=%b cs=%b want 1 0", m0_ack, mmio_cs); end
        m0_req = 1'b0;
        step();
        n_checks++;
        if (mmio_cs !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL late_idle got cs=%b busy=%b want 0 0", mmio_cs, busy); end
        step();
        n_checks++;
        if (mmio_cs !== 1'b1 || gnt_id !== 1'b1 || mmio_addr !== 21'h000400 || mmio_wr_data !== 32'h33334444) begin
            n_fail++; $display("[TB] FAIL late_m1_strobe got cs=%b gnt=%b addr=%h data=%h want 1 1 000400 33334444", mmio_cs, gnt_id, mmio_addr, mmio_wr_data);
        end
        step();
        n_checks++;
        if (m1_ack !== 1'b1) begin n_fail++; $display("[TB] FAIL late_m1_ack got %b want 1", m1_ack); end
        m1_req = 1'b0;
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_sustained();
        test_reset_mid_op();
        test_late_request();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpro_mmio_arbiter.md
# fpro_mmio_arbiter

Two-master arbiter that shares the single FPro MMIO bus (`mmio_cs/wr/rd/addr/wr_data/rd_data`) between requesters, e.g. the MicroBlaze MCS bridge (master 0) and a secondary bus master such as a UART debug loader or DMA engine (master 1). It sits between the masters and `mmio_sys_vanilla`.

- Each master gets a request/acknowledge handshake.
- Granted accesses become exactly one single-cycle FPro strobe.
- Contention is resolved round-robin.

## Interface
- `ADDR_W`, 21, MMIO word-address width.
- `DATA_W`, 32, data width.

- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `m0_req`, `m1_req` in 1: transaction request. Held high until the matching ack.
- `m0_wr`, `m1_wr` in 1: 1 = write, 0 = read. Stable while req is high.
- `m0_addr`, `m1_addr` in ADDR_W: target address. Stable while req is high.
- `m0_wr_data`, `m1_wr_data` in DATA_W: write data. Stable while req is high.
- `m0_rd_data`, `m1_rd_data` out DATA_W: registered read result for that master.
- `m0_ack`, `m1_ack` out 1: one-cycle completion pulse.
- `mmio_cs` out 1: FPro chip select. Single-cycle pulse.
- `mmio_wr`, `mmio_rd` out 1: FPro write/read strobes. Single-cycle pulses.
- `mmio_addr` out ADDR_W: latched address.
- `mmio_wr_data` out DATA_W: latched write data.
- `mmio_rd_data` in DATA_W: FPro read data, combinational from the slave.
- `busy` out 1: high in any state other than IDLE.
- `gnt_id` out 1: master that owns the current or most recent transaction.

## Operation
- FSM states:
  - IDLE: arbitrate. If any req is high, latch the winner's wr/addr/wr_data into `mmio_wr`-source regs, `mmio_addr` and `mmio_wr_data`, set `gnt_id`, and go to ISSUE.
  - ISSUE:
    - Assert `mmio_cs` = 1.
    - Assert `mmio_wr` = latched wr, `mmio_rd` = !latched wr.
    - If read, capture `mmio_rd_data` into the granted master's rd_data reg at the end of this cycle.
    - Go to ACK.
  - ACK: pulse ack of the granted master. Update the round-robin pointer `last` = `gnt_id`. Go to IDLE.
- Arbitration:
  - Only one master requesting: that master wins.
  - Both requesting: the master ≠ `last` wins.
  - `last` resets to 1, so master 0 wins the first contention.
- Requests are sampled only in IDLE. A req rising during ISSUE/ACK waits.
- Master protocol: drop req (or present a new transaction) no later than the cycle after ack.
  - A req still high in that IDLE cycle is treated as a new transaction. This is legal back-to-back use.
- Write completion leaves that master's rd_data unchanged.
- A read never alters the other master's rd_data.
- `mmio_addr`/`mmio_wr_data` hold their last latched value outside ISSUE. Slaves qualify them with `mmio_cs`.
- No timeout: the FPro slaves always complete in one cycle.

## Timing
- Reset values:
  - state = IDLE.
  - `mmio_cs`, `mmio_wr`, `mmio_rd` = 0.
  - `mmio_addr`, `mmio_wr_data` = 0.
  - `m0_rd_data`, `m1_rd_data` = 0.
  - `m0_ack`, `m1_ack` = 0.
  - `busy` = 0.
  - `gnt_id` = 0.
  - `last` = 1.
- All outputs are registered. No combinational path from any master input to any output.
- Latency, with req first high in cycle T (arbiter in IDLE):
  - Strobes are high in T+1.
  - ack and valid rd_data in T+2.
  - Back to IDLE in T+3.
- Throughput: one transaction per 3 cycles. Sustained contention alternates 0,1,0,1.
- `mmio_cs` is never high for two consecutive cycles. Exactly one of `mmio_wr`/`mmio_rd` is high when `mmio_cs` = 1.
- At most one ack per cycle. Never an ack without a preceding ISSUE for that master.
- Reset asserted in ISSUE or ACK:
  - Immediate return to IDLE with all strobes and acks 0.
  - The in-flight transaction is dropped with no ack.
  - The master must re-request after reset.

## Test plan
- Single read: m0 reads addr 0x000042 while the slave drives 0xDEADBEEF.
  - `mmio_cs` & `mmio_rd` high exactly at T+1 with `mmio_addr` = 0x000042.
  - `m0_ack` at T+2 with `m0_rd_data` = 0xDEADBEEF.
  - `m1_rd_data` stays 0.
- Single write: m1 writes 0x12345678 to 0x000100.
  - One-cycle `mmio_wr` at T+1 with matching addr/data.
  - `m1_ack` at T+2.
  - `m1_rd_data` unchanged.
- Contention from reset: m0 and m1 request simultaneously.
  - m0 is served first: ack at T+2, `gnt_id` = 0.
  - m1's strobe follows at T+4 and its ack at T+5.
- Sustained contention: both hold req through 6 transactions.
  - Grant order is 0,1,0,1,0,1.
  - `mmio_cs` period is 3 cycles and never high twice in a row.
- Reset mid-op: assert reset during ISSUE of an m0 read.
  - No `m0_ack`; all outputs are at reset values in the same cycle.
  - After release, a re-issued request completes normally in 3 cycles.
- Late request: m1 raises req during m0's ISSUE.
  - m1 is not strobed until m0's ack cycle has passed.
  - m1's strobe appears in the cycle after the IDLE sample.
